// File: rtl/wfg_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Holds the FSM state encoding, opcodes and response bytes.
package wfg_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_EXEC,
    ST_RESP,
    ST_WAIT_TX
  } state_t;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK  = 8'hAA;
  localparam logic [7:0] RSP_NAK  = 8'h55;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: reload on every accepted byte, expire after TIMEOUT_CYC idle cycles.
// Ports: clk, rst_n (sync, active-low), load, en, expired (comb, only while en).
module byte_timeout_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] RELOAD = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Loaded with TIMEOUT_CYC-1 so that expired is seen during the
  // TIMEOUT_CYC-th idle cycle and the abort lands on its closing edge.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses WRITE/READ frames from UART rx bytes, drives register bank, returns ACK/data/NAK.
// Ports: clk, rst_n, rx_done/rx_data, tx_done/tx_wr/tx_data, reg_wr/reg_addr/reg_wdata/reg_rdata, busy, err. Option: UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl
  import wfg_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_done,
  output logic       tx_wr,
  output logic [7:0] tx_data,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  state_t     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] rsp_q, rsp_d;
  logic       err_q, err_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       csum_ok_q, csum_ok_d;
`endif

  logic op_valid;
  logic in_frame;
  logic tmr_load;
  logic tmr_exp;
  logic frame_ok;

  assign op_valid = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA)
                 || (state_q == ST_CSUM);
  assign tmr_load = rx_done
                 && (in_frame || (state_q == ST_IDLE && op_valid));

`ifdef UART_CMD_CHECKSUM_EN
  assign frame_ok = (int'(addr_q) < NUM_REGS) && csum_ok_q;
`else
  assign frame_ok = (int'(addr_q) < NUM_REGS);
`endif

  byte_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (in_frame),
    .expired(tmr_exp)
  );

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      rsp_q     <= '0;
      err_q     <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q    <= '0;
      csum_ok_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rsp_q     <= rsp_d;
      err_q     <= err_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q    <= csum_d;
      csum_ok_q <= csum_ok_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          state_d = op_valid ? ST_ADDR : ST_RESP;
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_d = is_wr_q ? ST_DATA : ST_CSUM;
`else
          state_d = is_wr_q ? ST_DATA : ST_EXEC;
`endif
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
`ifdef UART_CMD_CHECKSUM_EN
          state_d = ST_CSUM;
`else
          state_d = ST_EXEC;
`endif
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_done) begin
          state_d = ST_EXEC;
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
        end
      end
`endif
      ST_EXEC:    state_d = ST_RESP;
      ST_RESP:    state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (tx_done) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath / sticky error update
  always_comb begin
    is_wr_d   = is_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rsp_d     = rsp_q;
    err_d     = err_q;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d    = csum_q;
    csum_ok_d = csum_ok_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_done) begin
          if (op_valid) begin
            is_wr_d = (rx_data == OP_WRITE);
`ifdef UART_CMD_CHECKSUM_EN
            csum_d  = rx_data;
`endif
          end else begin
            rsp_d = RSP_NAK;
            err_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (rx_done) begin
          addr_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
        end else if (tmr_exp) begin
          err_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (rx_done) begin
          data_d = rx_data;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
        end else if (tmr_exp) begin
          err_d = 1'b1;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_done) begin
          csum_ok_d = (rx_data == csum_q);
        end else if (tmr_exp) begin
          err_d = 1'b1;
        end
      end
`endif
      ST_EXEC: begin
        // Overrun first so a same-cycle ACK clears it.
        if (rx_done) begin
          err_d = 1'b1;
        end
        if (!frame_ok) begin
          rsp_d = RSP_NAK;
          err_d = 1'b1;
        end else if (is_wr_q) begin
          rsp_d = RSP_ACK;
          err_d = 1'b0;
        end else begin
          rsp_d = reg_rdata;
        end
      end
      ST_RESP, ST_WAIT_TX: begin
        if (rx_done) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != ST_IDLE);
    reg_wr    = (state_q == ST_EXEC) && is_wr_q && frame_ok;
    tx_wr     = (state_q == ST_RESP);
    tx_data   = rsp_q;
    reg_addr  = addr_q;
    reg_wdata = data_q;
    err       = err_q;
  end

endmodule
